idx_mask_collect: RTL and testbench

IDX_MASK_COLLECT -- requirements
Module: idx_mask_collect

---
 rtl/cf_math_pkg.sv | 8 +
 rtl/idx_mask_collect.sv | 88 ++++++++
 tb/tb_idx_mask_collect.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cf_math_pkg.sv
// cf_math_pkg: shared math helpers for index and counter sizing
package cf_math_pkg;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/idx_mask_collect.sv
// idx_mask_collect: accumulates a stream of bit indices into a mask and offers it once the last beat arrives
module idx_mask_collect
    import cf_math_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE = 0,
    localparam int IDX_WIDTH = idx_width(WIDTH),
    localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IDX_WIDTH-1:0] in_idx_i,
    input  logic                 in_empty_i,
    input  logic                 in_last_i,
    output logic                 mask_valid_o,
    input  logic                 mask_ready_i,
    output logic [WIDTH-1:0]     mask_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dup_o,
    output logic                 oor_o
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "idx_mask_collect: WIDTH must be at least 1");
    end

    typedef enum logic {COLLECT, OFFER} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     mask, hit;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 dup, oor;
    logic                 upd, in_range, is_set, offer_done;

    // one-hot decode of the incoming index; an out-of-range index matches no bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_hit
        assign hit[i] = (MODE == 0) ? (in_idx_i == IDX_WIDTH'(i))
                                    : (in_idx_i == IDX_WIDTH'(WIDTH - 1 - i));
    end

    assign in_range   = |hit;
    assign is_set     = |(hit & mask);
    assign upd        = in_valid_i && (state == COLLECT) && !in_empty_i;
    assign offer_done = (state == OFFER) && mask_ready_i;

    // next-state and handshake outputs; ready depends on state only
    always_comb begin
        state_next   = state;
        in_ready_o   = (state == COLLECT);
        mask_valid_o = (state == OFFER);
        if (state == COLLECT && in_valid_i && in_last_i) state_next = OFFER;
        if (offer_done) state_next = COLLECT;
    end

    // state register plus mask/count/flag accumulation, cleared on the offer handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= COLLECT;
            mask  <= '0;
            cnt   <= '0;
            dup   <= 1'b0;
            oor   <= 1'b0;
        end else begin
            state <= state_next;
            if (offer_done) begin
                mask <= '0;
                cnt  <= '0;
                dup  <= 1'b0;
                oor  <= 1'b0;
            end else if (upd) begin
                if (!in_range) oor <= 1'b1;
                else if (is_set) dup <= 1'b1;
                else begin
                    mask <= mask | hit;
                    cnt  <= cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign mask_o = mask;
    assign cnt_o  = cnt;
    assign dup_o  = dup;
    assign oor_o  = oor;

endmodule

// File: tb/tb_idx_mask_collect.sv
// tb_idx_mask_collect: randomized self-checking bench over several WIDTH/MODE instances
module tb_idx_mask_collect;

    localparam int N = 5;
    localparam int WS[N] = '{8, 8, 6, 32, 32};
    localparam int MS[N] = '{0, 1, 0, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        in_valid[N], in_empty[N], in_last[N], mask_ready[N];
    logic [4:0]  in_idx[N];
    logic        in_ready[N], mask_valid[N], dup[N], oor[N];
    logic [31:0] mask[N];
    logic [5:0]  cnt[N];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int IW = (W > 1) ? $clog2(W) : 1;
        localparam int CW = $clog2(W + 1);
        logic [W-1:0]  m;
        logic [CW-1:0] c;
        idx_mask_collect #(.WIDTH(W), .MODE(MS[g])) u_dut (
            .clk_i(clk), .rst_i(rst),
            .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
            .in_idx_i(in_idx[g][IW-1:0]), .in_empty_i(in_empty[g]), .in_last_i(in_last[g]),
            .mask_valid_o(mask_valid[g]), .mask_ready_i(mask_ready[g]),
            .mask_o(m), .cnt_o(c), .dup_o(dup[g]), .oor_o(oor[g])
        );
        assign mask[g] = 32'(m);
        assign cnt[g]  = 6'(c);
    end

    function automatic logic [41:0] pk(input bit v, input bit r, input bit d, input bit o, input int c, input logic [31:0] m);
        logic [5:0] c6;
        c6 = 6'(c);
        return {v, r, d, o, c6, m};
    endfunction

    function automatic logic [41:0] ob(input int k);
        return {mask_valid[k], in_ready[k], dup[k], oor[k], cnt[k], mask[k]};
    endfunction

    task automatic beat(input int k, input int idx, input bit e, input bit l);
        in_valid[k] = 1'b1;
        in_idx[k]   = 5'(idx);
        in_empty[k] = e;
        in_last[k]  = l;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_empty[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic ack(input int k);
        mask_ready[k] = 1'b1;
        @(posedge clk); #1;
        mask_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (ob(k) !== pk(0, 1, 0, 0, 0, 0))
                $display("FAIL reset inst%0d got=%h exp=%h", k, ob(k), pk(0, 1, 0, 0, 0, 0));
            else passed++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        beat(0, 0, 0, 0); beat(0, 3, 0, 0); beat(0, 7, 0, 1);
        total++;
        if (ob(0) !== pk(1, 0, 0, 0, 3, 32'h89))
            $display("FAIL w8m0_last got=%h exp=%h", ob(0), pk(1, 0, 0, 0, 3, 32'h89));
        else passed++;
        ack(0);
        beat(1, 0, 0, 0); beat(1, 0, 0, 1);
        total++;
        if (ob(1) !== pk(1, 0, 1, 0, 1, 32'h80))
            $display("FAIL w8m1_dup got=%h exp=%h", ob(1), pk(1, 0, 1, 0, 1, 32'h80));
        else passed++;
        ack(1);
        beat(2, 7, 0, 0); beat(2, 2, 1, 0); beat(2, 5, 0, 1);
        total++;
        if (ob(2) !== pk(1, 0, 0, 1, 1, 32'h20))
            $display("FAIL w6_oor_empty got=%h exp=%h", ob(2), pk(1, 0, 0, 1, 1, 32'h20));
        else passed++;
        ack(2);
        total++;
        if (ob(2) !== pk(0, 1, 0, 0, 0, 0))
            $display("FAIL w6_cleared got=%h exp=%h", ob(2), pk(0, 1, 0, 0, 0, 0));
        else passed++;
    endtask

    task automatic test_hold;
        beat(0, 1, 0, 0); beat(0, 2, 0, 1);
        in_valid[0] = 1'b1;
        in_idx[0]   = 5'd5;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ob(0) !== pk(1, 0, 0, 0, 2, 32'h06))
                $display("FAIL hold cyc%0d got=%h exp=%h", i, ob(0), pk(1, 0, 0, 0, 2, 32'h06));
            else passed++;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        ack(0);
        total++;
        if (ob(0) !== pk(0, 1, 0, 0, 0, 0))
            $display("FAIL hold_release got=%h exp=%h", ob(0), pk(0, 1, 0, 0, 0, 0));
        else passed++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 15; t++) begin
                bit seen[int];
                bit d, o;
                logic [31:0] m;
                int n;
                seen.delete();
                d = 0;
                o = 0;
                n = $urandom_range(1, 8);
                for (int b = 0; b < n; b++) begin
                    int idx;
                    bit e, l;
                    idx = $urandom_range(0, 7);
                    e = ($urandom_range(0, 4) == 0);
                    l = (b == n - 1);
                    beat(k, idx, e, l);
                    if (!e) begin
                        if (idx >= WS[k]) o = 1;
                        else if (seen.exists(MS[k] ? WS[k] - 1 - idx : idx)) d = 1;
                        else seen[MS[k] ? WS[k] - 1 - idx : idx] = 1;
                    end
                    m = '0;
                    foreach (seen[p]) m[p] = 1'b1;
                    total++;
                    if (ob(k) !== pk(l, !l, d, o, seen.num(), m))
                        $display("FAIL rand inst%0d mask%0d beat%0d got=%h exp=%h", k, t, b, ob(k), pk(l, !l, d, o, seen.num(), m));
                    else passed++;
                end
                ack(k);
            end
        end
    endtask

    task automatic test_round_trip;
        for (int k = 3; k < 5; k++) begin
            for (int t = 0; t < 9; t++) begin
                logic [31:0] v, r;
                v = (t == 0) ? 32'h0 : $urandom;
                r = v;
                while (r != 0) begin
                    int p;
                    p = -1;
                    for (int i = 0; i < 32; i++)
                        if (r[i] && (MS[k] == 1 || p < 0)) p = i;
                    beat(k, MS[k] ? 31 - p : p, 0, 0);
                    r[p] = 1'b0;
                end
                beat(k, 0, 1, 1);
                total++;
                if (ob(k) !== pk(1, 0, 0, 0, $countones(v), v))
                    $display("FAIL round_trip inst%0d v=%h got=%h exp=%h", k, v, ob(k), pk(1, 0, 0, 0, $countones(v), v));
                else passed++;
                ack(k);
            end
        end
    endtask

    task automatic test_reset_mid;
        beat(0, 1, 0, 0); beat(0, 4, 0, 0);
        rst = 1'b1;
        in_valid[0] = 1'b1;
        in_idx[0]   = 5'd6;
        in_last[0]  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ob(0) !== pk(0, 1, 0, 0, 0, 0))
            $display("FAIL reset_collect got=%h exp=%h", ob(0), pk(0, 1, 0, 0, 0, 0));
        else passed++;
        beat(1, 3, 0, 0); beat(1, 3, 0, 1);
        rst = 1'b1;
        mask_ready[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mask_ready[1] = 1'b0;
        total++;
        if (ob(1) !== pk(0, 1, 0, 0, 0, 0))
            $display("FAIL reset_offer got=%h exp=%h", ob(1), pk(0, 1, 0, 0, 0, 0));
        else passed++;
        @(posedge clk); #1;
        total++;
        if (ob(1) !== pk(0, 1, 0, 0, 0, 0))
            $display("FAIL reset_no_offer got=%h exp=%h", ob(1), pk(0, 1, 0, 0, 0, 0));
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            in_valid[k] = 1'b0;
            in_empty[k] = 1'b0;
            in_last[k] = 1'b0;
            mask_ready[k] = 1'b0;
            in_idx[k] = '0;
        end
        test_reset;
        test_directed;
        test_hold;
        test_random;
        test_round_trip;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
